// File: rtl/apb_timer_slv_if.sv
// APB bus bundle between the peripheral bridge and the timer responder.
interface apb_timer_slv_if #(
  parameter int PADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [PADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_slv.sv
// APB responder: prescaled down-counting timer with auto-reload, W1C status,
// level irq, and a fixed number of access-phase wait states.
module apb_timer_slv #(
  parameter int PADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            pclk,
  input  logic            preset,
  apb_timer_slv_if.slave  bus,
  output logic            irq
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t                 state, nxt;
  logic [3:0]             wcnt;
  logic                   ctrl_en, ctrl_ar, ctrl_ie;
  logic [7:0]             ctrl_p;
  logic [DATA_WIDTH-1:0]  load_q, value_q;
  logic                   expired;
  logic [7:0]             pc;

  logic                   err;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   commit, wr_ctrl, wr_load, wr_stat;
  logic                   tick, expire;

  // Address decode, error classification and read mux for the current bus address
  always_comb begin
    rdata = '0;
    err   = (|bus.paddr[PADDR_WIDTH-1:4]) | (|bus.paddr[1:0]) |
            (bus.pwrite & (bus.paddr[3:2] == 2'd2));
    case (bus.paddr[3:2])
      2'd0: begin
        rdata[0]    = ctrl_en;
        rdata[1]    = ctrl_ar;
        rdata[2]    = ctrl_ie;
        rdata[11:4] = ctrl_p;
      end
      2'd1:    rdata = load_q;
      2'd2:    rdata = value_q;
      default: rdata[0] = expired;
    endcase
  end

  // A write lands at the end of RESP only if the master is still selecting us
  // and the response registered on RESP entry was not an error.
  assign commit  = (state == ST_RESP) & bus.psel & bus.penable & bus.pwrite & ~bus.pslverr;
  assign wr_ctrl = commit & (bus.paddr[3:2] == 2'd0);
  assign wr_load = commit & (bus.paddr[3:2] == 2'd1);
  assign wr_stat = commit & (bus.paddr[3:2] == 2'd3);

  assign tick    = ctrl_en & (pc == ctrl_p);
  assign expire  = tick & (value_q <= DATA_WIDTH'(1));
  assign irq     = expired & ctrl_ie;

  // APB next-state: setup phase starts a transfer, dropping psel abandons it
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.psel & ~bus.penable) nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (!bus.psel) nxt = ST_IDLE;
               else if (wcnt == 4'd1) nxt = ST_RESP;
      default: nxt = ST_IDLE;
    endcase
  end

  // APB state, wait counter and registered response captured on RESP entry
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata  <= '0;
    end else begin
      state      <= nxt;
      bus.pready <= (nxt == ST_RESP);
      if (state == ST_IDLE && nxt == ST_WAIT) wcnt <= WC;
      else if (state == ST_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
      if (nxt == ST_RESP) begin
        bus.pslverr <= err;
        bus.prdata  <= err ? '0 : rdata;
      end
    end
  end

  // Timer registers; software writes win over the counter except that a
  // hardware expiry set beats a same-cycle W1C.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_en <= 1'b0;
      ctrl_ar <= 1'b0;
      ctrl_ie <= 1'b0;
      ctrl_p  <= '0;
      load_q  <= '0;
      value_q <= '0;
      expired <= 1'b0;
      pc      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= bus.pwdata[0];
        ctrl_ar <= bus.pwdata[1];
        ctrl_ie <= bus.pwdata[2];
        ctrl_p  <= bus.pwdata[11:4];
      end else if (expire & ~ctrl_ar) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load) begin
        load_q  <= bus.pwdata;
        value_q <= bus.pwdata;
      end else if (tick) begin
        if (value_q > DATA_WIDTH'(1)) value_q <= value_q - DATA_WIDTH'(1);
        else                          value_q <= ctrl_ar ? load_q : '0;
      end

      if (!ctrl_en || wr_load || tick) pc <= '0;
      else                             pc <= pc + 8'd1;

      if (expire)                         expired <= 1'b1;
      else if (wr_stat && bus.pwdata[0]) expired <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_timer_slv.sv
// Directed bench for apb_timer_slv: the driver queues the expected response of
// each transfer, an independent monitor checks it when pready appears.
module tb_apb_timer_slv;
  localparam int WC = 1;

  logic pclk = 1'b0;
  logic preset;
  logic irq;

  apb_timer_slv_if #(.PADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  apb_timer_slv #(.PADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(WC)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] rd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every pready must match the oldest queued expectation
  always @(negedge pclk) begin
    if (!preset && bus.psel && bus.pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready act=1 exp=0");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_slverr"}, {31'd0, bus.pslverr}, {31'd0, e.err});
        if (e.chk) chk({nm, "_prdata"}, bus.prdata, e.rd);
      end
    end
  end

  // One APB transfer; returns 1 ns after the commit edge
  task automatic apb(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic xerr, input logic xchk, input logic [31:0] xrd,
                     input string nm);
    int   n;
    logic got;
    exp_q.push_back('{err: xerr, chk: xchk, rd: xrd});
    name_q.push_back(nm);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    n = 1; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge pclk); #1;
      n++;
      if (bus.pready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout act=no_pready exp=pready", nm);
    end else begin
      chk({nm, "_pready_cyc"}, 32'(n), 32'(WC + 1));
    end
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr_ok(input logic [15:0] a, input logic [31:0] d, input string nm);
    apb(1'b1, a, d, 1'b0, 1'b0, 32'd0, nm);
  endtask

  task automatic rd_ok(input logic [15:0] a, input logic [31:0] x, input string nm);
    apb(1'b0, a, 32'd0, 1'b0, 1'b1, x, nm);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge pclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    cyc(3);
    preset = 1'b0;

    // Reset state
    chk("rst_pready", {31'd0, bus.pready}, 32'd0);
    chk("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_ok(16'h0, 32'h0, "rst_ctrl");
    rd_ok(16'h4, 32'h0, "rst_load");
    rd_ok(16'h8, 32'h0, "rst_value");
    rd_ok(16'hC, 32'h0, "rst_status");

    // One-shot, P=0, N=3: expiry 3 cycles after the enable commit
    wr_ok(16'h4, 32'd3, "os_load");
    wr_ok(16'h0, 32'h5, "os_ctrl");
    cyc(2);
    chk("os_irq_early", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("os_irq_at3", {31'd0, irq}, 32'd1);
    rd_ok(16'h0, 32'h4, "os_ctrl_en_clr");
    rd_ok(16'h8, 32'h0, "os_value0");
    wr_ok(16'hC, 32'h0, "os_w0");
    rd_ok(16'hC, 32'h1, "os_status_kept");
    wr_ok(16'hC, 32'h1, "os_w1c");
    rd_ok(16'hC, 32'h0, "os_status_clr");
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // Error responses leave registers alone
    wr_ok(16'h4, 32'h1234, "er_load");
    apb(1'b1, 16'h8,  32'h55,   1'b1, 1'b1, 32'h0, "er_wr_value");
    apb(1'b1, 16'h14, 32'hFFFF, 1'b1, 1'b1, 32'h0, "er_wr_0x14");
    apb(1'b1, 16'h10, 32'h7,    1'b1, 1'b1, 32'h0, "er_wr_0x10");
    apb(1'b0, 16'h2,  32'h0,    1'b1, 1'b1, 32'h0, "er_rd_0x2");
    rd_ok(16'h4, 32'h1234, "er_load_kept");
    rd_ok(16'h8, 32'h1234, "er_value_kept");
    rd_ok(16'h0, 32'h4, "er_ctrl_kept");

    // Auto-reload, P=2, N=2: expiries every 6 cycles
    wr_ok(16'h4, 32'd2, "ar_load");
    wr_ok(16'h0, 32'h27, "ar_ctrl");
    cyc(5);
    chk("ar_irq_early", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("ar_irq_at6", {31'd0, irq}, 32'd1);
    rd_ok(16'h8, 32'd2, "ar_reloaded");
    wr_ok(16'hC, 32'h1, "ar_w1c");
    chk("ar_irq_dropped", {31'd0, irq}, 32'd0);
    cyc(3);
    chk("ar_irq_early2", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("ar_irq_at12", {31'd0, irq}, 32'd1);
    // W1C commit lands on the next expiry edge: hardware set wins
    cyc(2);
    wr_ok(16'hC, 32'h1, "col_w1c");
    chk("col_irq_kept", {31'd0, irq}, 32'd1);
    wr_ok(16'hC, 32'h1, "col_w1c2");
    chk("col_irq_clr", {31'd0, irq}, 32'd0);
    wr_ok(16'h0, 32'h0, "ar_stop");
    wr_ok(16'hC, 32'h1, "ar_w1c3");
    rd_ok(16'hC, 32'h0, "ar_status_clr");
    rd_ok(16'h8, 32'd2, "ar_value_final");

    // Reset during WAIT of a CTRL write abandons it
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 16'h0; bus.pwdata = 32'h5;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    chk("ra_pready0", {31'd0, bus.pready}, 32'd0);
    @(posedge pclk); #1;
    chk("ra_pready1", {31'd0, bus.pready}, 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    rd_ok(16'h0, 32'h0, "ra_ctrl0");
    chk("ra_irq", {31'd0, irq}, 32'd0);
    wr_ok(16'h4, 32'd7, "ra_load");
    rd_ok(16'h4, 32'd7, "ra_load_rd");

    cyc(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_timer_slv.md
# apb_timer_slv

APB responder implementing a programmable down-counting timer with a prescaler, auto-reload and a level interrupt. It is one of the PSLV_NUM peripheral slots behind the AHB-to-APB bridge. It runs on the divided peripheral clock and supplies a known-good responder with configurable wait states, error responses and an IRQ line for bring-up.

## Interface
- PADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 32, APB data width; fixed at 32 for this block
- WAIT_CYCLES, 1, extra access-phase cycles inserted before pready (0..15)
- pclk  in  1  peripheral clock; the only clock
- preset  in  1  reset, synchronous and active-high
- psel  in  1  slave select from bridge
- penable  in  1  APB access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  PADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, valid while pready=1
- pready  out  1  transfer-complete, registered
- pslverr  out  1  error response, valid while pready=1
- irq  out  1  level interrupt = STATUS.expired & CTRL.irq_en, from flops

## Operation
- Register map, decoded on paddr[3:2]:
  - 0x0 CTRL (RW): bit0 en, bit1 auto_reload, bit2 irq_en, bits[11:4] prescale P. All other bits read 0.
  - 0x4 LOAD (RW): 32-bit reload value. A write also copies the value into VALUE and clears the prescale counter.
  - 0x8 VALUE (RO): current count.
  - 0xC STATUS: bit0 expired. Writing 1 clears it; writing 0 has no effect.
- Error responses (pslverr=1, write discarded, prdata=0):
  - paddr[PADDR_WIDTH-1:4] != 0
  - paddr[1:0] != 0
  - any write to VALUE
- APB FSM states: IDLE, WAIT, RESP.
  - IDLE: if psel & ~penable (setup phase), go to RESP when WAIT_CYCLES=0; otherwise go to WAIT with wcnt=WAIT_CYCLES.
  - WAIT: wcnt decrements each cycle; when wcnt=1, go to RESP.
  - RESP: pready=1. prdata and pslverr are registered on entry to RESP. A write commits at the end of the RESP cycle. Next state is IDLE.
  - If psel drops while in WAIT or RESP, return to IDLE with no commit.
- Prescaler:
  - When en=1, pc counts 0..P and wraps.
  - A tick is generated in each cycle where pc==P.
  - While en=0, pc is held at 0.
- Counter, on each tick:
  - If VALUE>1: VALUE-=1.
  - Else (VALUE≤1): expired<=1. If auto_reload=1, VALUE<=LOAD; otherwise VALUE<=0 and en<=0.
- LOAD=0 with auto_reload=1 expires on every tick.
- Simultaneous events:
  - Hardware set of expired beats a same-cycle W1C.
  - A LOAD write beats a same-cycle tick decrement.
  - A CTRL write beats the hardware clear of en.

## Timing
- Reset (synchronous, preset=1 at a pclk edge):
  - FSM to IDLE.
  - prdata=0, pready=0, pslverr=0, irq=0.
  - CTRL, LOAD, VALUE, STATUS, pc and wcnt all 0.
- Reset asserted mid-transfer abandons the transfer. No write commits, and pready stays 0 the following cycle.
- Access phase lasts exactly WAIT_CYCLES+1 cycles. pready is high for exactly 1 cycle per transfer.
- Timer timing: with P and LOAD=N≥1 written before en, expired rises N·(P+1) cycles after the CTRL-enable commit edge. irq follows in the same cycle when irq_en=1.
- Register writes take effect on the cycle after the commit edge. Reads return the value present on the cycle of RESP entry.

## Test plan
- Reset then read all four registers → prdata=0, pslverr=0 for each; irq=0; with WAIT_CYCLES=1, pready is high on the 2nd penable cycle.
- Write LOAD=3, then CTRL=0x5 (en, irq_en, P=0) → VALUE reads 2,1 on successive cycles; expired=1 and irq=1 exactly 3 cycles after commit; en auto-clears and VALUE=0.
- LOAD=2, CTRL=0x27 (P=2, auto_reload) → irq at 6 cycles; VALUE reloads to 2; a W1C to STATUS drops irq; the next expiry comes 6 cycles later.
- Write VALUE, paddr=0x10 and paddr=0x2 → pslverr=1 with pready, prdata=0, no register changes.
- W1C STATUS committing on the same cycle as an expiry tick → expired stays 1.
- preset during WAIT of a CTRL write → CTRL stays 0; pready does not pulse; the next transfer completes normally.
